// File: rtl/mac_dot_sequencer_if.sv
// Job, operand, MAC-issue and result signals of the dot-product sequencer.
// Names are seen from the sequencer: i_* flow into it, o_* out of it.
interface mac_dot_sequencer_if #(
  parameter int DATA_A_WIDTH = 8,
  parameter int DATA_B_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 32,
  parameter int LEN_WIDTH    = 8
);
  logic                           i_start;
  logic [LEN_WIDTH-1:0]           i_len;
  logic signed [ACCUM_WIDTH-1:0]  i_bias;
  logic                           o_busy;
  logic                           i_in_valid;
  logic                           o_in_ready;
  logic signed [DATA_A_WIDTH-1:0] i_in_a;
  logic signed [DATA_B_WIDTH-1:0] i_in_b;
  logic                           o_mac_en;
  logic signed [DATA_A_WIDTH-1:0] o_mac_data_a;
  logic signed [DATA_B_WIDTH-1:0] o_mac_data_b;
  logic signed [ACCUM_WIDTH-1:0]  o_mac_accum_in;
  logic signed [ACCUM_WIDTH-1:0]  i_mac_accum_out;
  logic                           o_out_valid;
  logic                           i_out_ready;
  logic signed [ACCUM_WIDTH-1:0]  o_out_result;

  modport slave (
    input  i_start, i_len, i_bias,
    output o_busy,
    input  i_in_valid, i_in_a, i_in_b,
    output o_in_ready,
    output o_mac_en, o_mac_data_a,
    output o_mac_data_b, o_mac_accum_in,
    input  i_mac_accum_out,
    output o_out_valid, o_out_result,
    input  i_out_ready
  );

  modport master (
    output i_start, i_len, i_bias,
    input  o_busy,
    output i_in_valid, i_in_a, i_in_b,
    input  o_in_ready,
    input  o_mac_en, o_mac_data_a,
    input  o_mac_data_b, o_mac_accum_in,
    output i_mac_accum_out,
    input  o_out_valid, o_out_result,
    output i_out_ready
  );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Drives a mac_unit through len operand pairs, chaining each result
// back as the next accumulator input, then offers the final sum.
module mac_dot_sequencer #(
  parameter int DATA_A_WIDTH = 8,
  parameter int DATA_B_WIDTH = 8,
  parameter int ACCUM_WIDTH  = 32,
  parameter int LEN_WIDTH    = 8,
  parameter int MAC_LATENCY  = 2
) (
  input logic clk,
  input logic rst,
  mac_dot_sequencer_if.slave bus
);
  localparam int WCW =
    (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [ACCUM_WIDTH-1:0]  r_acc;
  logic [LEN_WIDTH-1:0]           r_rem;
  logic [WCW-1:0]                 r_wcnt;
  logic                           r_mac_en;
  logic signed [DATA_A_WIDTH-1:0] r_mac_a;
  logic signed [DATA_B_WIDTH-1:0] r_mac_b;
  logic signed [ACCUM_WIDTH-1:0]  r_mac_acc;
  logic signed [ACCUM_WIDTH-1:0]  r_result;

  logic w_in_ready;
  logic w_busy;
  logic w_out_valid;
  logic w_last;

  assign w_last = (r_rem == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.i_start)
          w_next = (bus.i_len == '0) ? S_DONE : S_FETCH;
      S_FETCH:
        if (bus.i_in_valid) w_next = S_ISSUE;
      S_ISSUE:
        w_next = S_WAIT;
      S_WAIT:
        if (r_wcnt == '0)
          w_next = w_last ? S_DONE : S_FETCH;
      S_DONE:
        if (bus.i_out_ready) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    unique case (1'b1)
      (r_state == S_IDLE):  w_busy      = 1'b0;
      (r_state == S_FETCH): w_in_ready  = 1'b1;
      (r_state == S_DONE):  w_out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath only moves on state-qualified edges; no adders on data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_rem     <= '0;
      r_wcnt    <= '0;
      r_mac_en  <= 1'b0;
      r_mac_a   <= '0;
      r_mac_b   <= '0;
      r_mac_acc <= '0;
      r_result  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE:
          if (bus.i_start) begin
            r_acc <= bus.i_bias;
            r_rem <= bus.i_len;
            if (bus.i_len == '0) r_result <= bus.i_bias;
          end
        S_FETCH:
          if (bus.i_in_valid) begin
            r_mac_a   <= bus.i_in_a;
            r_mac_b   <= bus.i_in_b;
            r_mac_acc <= r_acc;
            r_mac_en  <= 1'b1;
          end
        S_ISSUE: begin
          r_mac_en <= 1'b0;
          r_wcnt   <= WCW'(MAC_LATENCY - 1);
        end
        S_WAIT:
          if (r_wcnt == '0) begin
            r_acc <= bus.i_mac_accum_out;
            r_rem <= r_rem - LEN_WIDTH'(1);
            if (w_last) r_result <= bus.i_mac_accum_out;
          end else begin
            r_wcnt <= r_wcnt - WCW'(1);
          end
        default: ;
      endcase
    end
  end

  assign bus.o_busy         = w_busy;
  assign bus.o_in_ready     = w_in_ready;
  assign bus.o_out_valid    = w_out_valid;
  assign bus.o_mac_en       = r_mac_en;
  assign bus.o_mac_data_a   = r_mac_a;
  assign bus.o_mac_data_b   = r_mac_b;
  assign bus.o_mac_accum_in = r_mac_acc;
  assign bus.o_out_result   = r_result;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a 2-stage MAC model
// standing in for mac_unit (8/8/32, latency 2).
module tb_mac_dot_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mac_dot_sequencer_if #(8, 8, 32, 8) bus ();

  mac_dot_sequencer #(
    .DATA_A_WIDTH(8),
    .DATA_B_WIDTH(8),
    .ACCUM_WIDTH (32),
    .LEN_WIDTH   (8),
    .MAC_LATENCY (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // MAC stand-in: multiply-accumulate on en, result one edge later.
  logic signed [31:0] m_p1;
  logic signed [31:0] m_out;
  always_ff @(posedge clk) begin
    if (rst) begin
      m_p1  <= '0;
      m_out <= '0;
    end else begin
      if (bus.o_mac_en)
        m_p1 <= bus.o_mac_data_a * bus.o_mac_data_b
              + bus.o_mac_accum_in;
      m_out <= m_p1;
    end
  end
  assign bus.i_mac_accum_out = m_out;

  int en_cnt = 0;
  int consec_cnt = 0;
  int rdy_cnt = 0;
  int ov_cnt = 0;
  logic en_prev = 1'b0;
  logic signed [31:0] acc_log [0:63];

  always @(negedge clk) begin
    if (bus.o_mac_en) begin
      acc_log[en_cnt[5:0]] = bus.o_mac_accum_in;
      en_cnt = en_cnt + 1;
      if (en_prev) consec_cnt = consec_cnt + 1;
    end
    en_prev = bus.o_mac_en;
    if (bus.o_in_ready) rdy_cnt = rdy_cnt + 1;
    if (bus.o_out_valid) ov_cnt = ov_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cyc;

  task automatic feed(input logic signed [7:0] a,
                      input logic signed [7:0] b);
    logic hs;
    hs = 1'b0;
    bus.i_in_a     = a;
    bus.i_in_b     = b;
    bus.i_in_valid = 1'b1;
    for (int k = 0; k < 50 && !hs; k++) begin
      hs = bus.o_in_ready;
      tick();
      cyc++;
    end
    bus.i_in_valid = 1'b0;
    chk("feed_handshake", hs, 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && !bus.o_out_valid; k++) begin
      tick();
      cyc++;
    end
    chk("out_valid_seen", bus.o_out_valid, 1);
  endtask

  task automatic start_job(input logic [7:0] len,
                           input logic signed [31:0] bias);
    bus.i_start = 1'b1;
    bus.i_len   = len;
    bus.i_bias  = bias;
    tick();
    bus.i_start = 1'b0;
    cyc = 1;
  endtask

  int base_en;
  int base_rdy;
  int base_ov;
  logic stable;

  initial begin
    bus.i_start     = 1'b0;
    bus.i_len       = '0;
    bus.i_bias      = '0;
    bus.i_in_valid  = 1'b0;
    bus.i_in_a      = '0;
    bus.i_in_b      = '0;
    bus.i_out_ready = 1'b0;
    cyc = 0;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy",     bus.o_busy, 0);
    chk("rst_in_ready", bus.o_in_ready, 0);
    chk("rst_mac_en",   bus.o_mac_en, 0);
    chk("rst_data_a",   bus.o_mac_data_a, 0);
    chk("rst_data_b",   bus.o_mac_data_b, 0);
    chk("rst_accum_in", bus.o_mac_accum_in, 0);
    chk("rst_out_valid", bus.o_out_valid, 0);
    chk("rst_out_result", bus.o_out_result, 0);
    rst = 1'b0;
    tick();

    // basic job: 10 + 15 - 24 + 0 = 1
    base_en = en_cnt;
    start_job(8'd3, 32'sd10);
    chk("basic_busy", bus.o_busy, 1);
    feed(8'sd5, 8'sd3);
    feed(-8'sd4, 8'sd6);
    feed(8'sd0, 8'sd10);
    wait_done();
    chk("basic_latency", cyc, 13);
    chk("basic_result", bus.o_out_result, 1);
    chk("basic_en_pulses", en_cnt - base_en, 3);
    chk("basic_acc0", acc_log[base_en[5:0]], 10);
    chk("basic_acc1", acc_log[6'(base_en + 1)], 25);
    chk("basic_acc2", acc_log[6'(base_en + 2)], 1);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;
    chk("basic_busy_after", bus.o_busy, 0);
    chk("basic_ovalid_after", bus.o_out_valid, 0);

    // empty job
    base_en  = en_cnt;
    base_rdy = rdy_cnt;
    start_job(8'd0, -32'sd7);
    chk("empty_out_valid", bus.o_out_valid, 1);
    chk("empty_result", bus.o_out_result, -7);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;
    chk("empty_en_pulses", en_cnt - base_en, 0);
    chk("empty_in_ready", rdy_cnt - base_rdy, 0);
    chk("empty_busy_after", bus.o_busy, 0);

    // extremes with operand stall and result backpressure
    base_en = en_cnt;
    start_job(8'd2, 32'sd0);
    feed(8'sd127, 8'sd127);
    for (int k = 0; k < 20 && !bus.o_in_ready; k++) tick();
    tick();
    tick();
    tick();
    chk("stall_in_ready", bus.o_in_ready, 1);
    chk("stall_en_pulses", en_cnt - base_en, 1);
    feed(-8'sd128, -8'sd128);
    wait_done();
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (bus.o_out_result !== 32'sd32513 || !bus.o_out_valid)
        stable = 1'b0;
      tick();
    end
    chk("bp_result", bus.o_out_result, 32513);
    chk("bp_stable", stable, 1);
    chk("bp_en_pulses", en_cnt - base_en, 2);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;
    chk("bp_ovalid_after", bus.o_out_valid, 0);

    // abort during WAIT of pair 2
    start_job(8'd2, 32'sd0);
    feed(8'sd1, 8'sd1);
    feed(8'sd2, 8'sd2);
    tick();
    base_ov = ov_cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_mac_en", bus.o_mac_en, 0);
    chk("abort_accum_in", bus.o_mac_accum_in, 0);
    chk("abort_result", bus.o_out_result, 0);
    for (int k = 0; k < 6; k++) tick();
    chk("abort_no_ovalid", ov_cnt - base_ov, 0);
    start_job(8'd1, 32'sd0);
    feed(8'sd2, 8'sd3);
    wait_done();
    chk("after_abort_result", bus.o_out_result, 6);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;

    // wrap
    start_job(8'd1, 32'sh7FFF_FFFF);
    feed(8'sd1, 8'sd1);
    wait_done();
    chk("wrap_result", bus.o_out_result, -64'sd2147483648);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_out_ready = 1'b0;

    // start while busy is ignored: 3*4 + 5*6 = 42
    base_en = en_cnt;
    start_job(8'd2, 32'sd0);
    bus.i_start = 1'b1;
    bus.i_len   = 8'd5;
    bus.i_bias  = 32'sd1000;
    feed(8'sd3, 8'sd4);
    feed(8'sd5, 8'sd6);
    wait_done();
    chk("ign_result", bus.o_out_result, 42);
    chk("ign_en_pulses", en_cnt - base_en, 2);
    bus.i_out_ready = 1'b1;
    tick();
    bus.i_start     = 1'b0;
    bus.i_out_ready = 1'b0;
    chk("ign_busy_after", bus.o_busy, 0);
    tick();
    chk("ign_still_idle", bus.o_busy, 0);

    chk("en_never_consec", consec_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
